// File: rtl/snake_body_ctrl_pkg.sv
// snake_pkg: shared types and constants for the snake body controller.
//   - dir_t encoding (00 right, 01 up, 10 left, 11 down) and reverse_dir()
//   - plot colours (erase is always black)
//   - default screen bounds (160 x 120 cells)
//   - FSM state encoding for snake_body_ctrl
// No ports; imported by snake_body_ctrl.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_UP    = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  localparam logic [2:0] COLOUR_ERASE = 3'b000;
  localparam logic [2:0] COLOUR_SNAKE = 3'b010;

  localparam int X_MAX_DEF = 159;
  localparam int Y_MAX_DEF = 119;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADVANCE,
    ST_SCAN,
    ST_CHECK,
    ST_ERASE,
    ST_DRAW,
    ST_OVER
  } state_t;

  // Opposite directions differ only in bit 1 of the encoding.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/snake_body_ctrl_if.sv
// snake_body_ctrl_if: pixel request channel from the snake controller to the
// VGA plotter (valid/ready handshake).
//   plot_valid   request valid (master -> slave)
//   plot_ready   plotter accepts request (slave -> master)
//   plot_x       pixel column, 8 bits
//   plot_y       pixel row, 7 bits
//   plot_colour  pixel colour, 3 bits
interface snake_body_ctrl_if;
  logic       plot_valid;
  logic       plot_ready;
  logic [7:0] plot_x;
  logic [6:0] plot_y;
  logic [2:0] plot_colour;

  modport master (
    output plot_valid, plot_x, plot_y, plot_colour,
    input  plot_ready
  );

  modport slave (
    input  plot_valid, plot_x, plot_y, plot_colour,
    output plot_ready
  );
endinterface

// File: rtl/snake_body_ctrl_seg_buf.sv
// snake_seg_buf: MAX_LEN x 15-bit circular store of body segments {x[7:0], y[6:0]}.
// One synchronous write port, one asynchronous read port. Pointer arithmetic
// lives in the parent. Reset loads the starting body: entry k holds
// (START_X-(START_LEN-1-k), START_Y), so entry 0 is the tail and entry
// START_LEN-1 is the head.
//   clock, resetn          clock and async active-low reset
//   wr_en/wr_addr/wr_data  write port
//   rd_addr/rd_data        combinational read port
module snake_seg_buf #(
  parameter int  MAX_LEN   = 32,
  parameter int  START_LEN = 4,
  parameter int  START_X   = 80,
  parameter int  START_Y   = 60,
  localparam int AW        = $clog2(MAX_LEN)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [14:0]   wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [14:0]   rd_data
);

  logic [14:0] mem [MAX_LEN];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (i < START_LEN) mem[i] <= {8'(START_X - (START_LEN - 1 - i)), 7'(START_Y)};
        else               mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/snake_body_ctrl.sv
// snake_body_ctrl: owns the snake body (circular buffer), advances the head one
// cell per tick, checks self-collision, handshakes food eating with the food
// block and issues erase-tail / draw-head pixel requests to the plotter.
//   clock, resetn      clock, async active-low reset
//   tick               move strobe (dropped unless IDLE)
//   dir_req/dir_valid  requested direction; 180-degree reversals ignored
//   food_hit           head-on-food flag from the food block
//   head_x/head_y      current head cell
//   food_regen         one-cycle pulse when food is eaten
//   plot               pixel request channel (master side)
//   length             current segment count
//   game_over          sticky self-collision flag
//   busy               high while a move is in progress
// Build option: SNAKE_WALL_KILL_EN -- leaving the screen ends the game instead
// of wrapping; the head then keeps its last legal cell.
//
// state   | meaning
// IDLE    | waiting for tick
// ADVANCE | commit direction, step head, bump head pointer
// SCAN    | compare new head with old segments (tail excluded), one per cycle
// CHECK   | sample food_hit, write head into buffer, stage first pixel request
// ERASE   | tail pixel request outstanding
// DRAW    | head pixel request outstanding
// OVER    | game over, wait for reset
module snake_body_ctrl
  import snake_pkg::*;
#(
  parameter int         MAX_LEN      = 32,
  parameter int         START_LEN    = 4,
  parameter int         START_X      = 80,
  parameter int         START_Y      = 60,
  parameter int         X_MAX        = X_MAX_DEF,
  parameter int         Y_MAX        = Y_MAX_DEF,
  parameter logic [2:0] SNAKE_COLOUR = COLOUR_SNAKE,
  localparam int        AW           = $clog2(MAX_LEN),
  localparam int        LW           = AW + 1
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              tick,
  input  logic [1:0]        dir_req,
  input  logic              dir_valid,
  input  logic              food_hit,
  output logic [7:0]        head_x,
  output logic [6:0]        head_y,
  output logic              food_regen,
  snake_body_ctrl_if.master plot,
  output logic [LW-1:0]     length,
  output logic              game_over,
  output logic              busy
);

  state_t        state_q, state_d;
  dir_t          dir_q, pend_q, dir_ref;
  logic [AW-1:0] head_ptr, tail_ptr, scan_ptr, rd_addr;
  logic [LW-1:0] scan_cnt;
  logic [14:0]   seg_rd;
  logic [7:0]    nx;
  logic [6:0]    ny;
  logic          head_step, accept, scan_hit, grow, wr_en;

  snake_seg_buf #(
    .MAX_LEN   (MAX_LEN),
    .START_LEN (START_LEN),
    .START_X   (START_X),
    .START_Y   (START_Y)
  ) u_seg_buf (
    .clock   (clock),
    .resetn  (resetn),
    .wr_en   (wr_en),
    .wr_addr (head_ptr),
    .wr_data ({head_x, head_y}),
    .rd_addr (rd_addr),
    .rd_data (seg_rd)
  );

  // Single read port: SCAN walks the body, otherwise the tail is presented so
  // CHECK can capture it before the head write (they share a slot when full).
  assign rd_addr  = (state_q == ST_SCAN) ? scan_ptr : tail_ptr;
  assign wr_en    = (state_q == ST_CHECK);
  assign scan_hit = (seg_rd == {head_x, head_y});
  assign grow     = food_hit && (length < LW'(MAX_LEN));
  assign accept   = plot.plot_valid && plot.plot_ready;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_OVER);
  // During ADVANCE the pending direction is what gets committed, so a request
  // in that cycle must be judged against it.
  assign dir_ref  = (state_q == ST_ADVANCE) ? pend_q : dir_q;

  always_comb begin
    nx = head_x;
    ny = head_y;
    case (pend_q)
      DIR_RIGHT: nx = (head_x == 8'(X_MAX)) ? 8'd0 : head_x + 8'd1;
      DIR_LEFT:  nx = (head_x == 8'd0) ? 8'(X_MAX) : head_x - 8'd1;
      DIR_UP:    ny = (head_y == 7'd0) ? 7'(Y_MAX) : head_y - 7'd1;
      DIR_DOWN:  ny = (head_y == 7'(Y_MAX)) ? 7'd0 : head_y + 7'd1;
      default:   ;
    endcase
  end

`ifdef SNAKE_WALL_KILL_EN
  logic off_edge;
  always_comb begin
    off_edge = 1'b0;
    case (pend_q)
      DIR_RIGHT: off_edge = (head_x == 8'(X_MAX));
      DIR_LEFT:  off_edge = (head_x == 8'd0);
      DIR_UP:    off_edge = (head_y == 7'd0);
      DIR_DOWN:  off_edge = (head_y == 7'(Y_MAX));
      default:   off_edge = 1'b0;
    endcase
  end
  assign head_step = ~off_edge;
`else
  assign head_step = 1'b1;
`endif

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    food_regen = 1'b0;
    case (state_q)
      ST_IDLE:    if (tick) state_d = ST_ADVANCE;
      ST_ADVANCE: state_d = head_step ? ST_SCAN : ST_OVER;
      ST_SCAN: begin
        if (scan_hit)                   state_d = ST_OVER;
        else if (scan_cnt == LW'(1))    state_d = ST_CHECK;
      end
      ST_CHECK: begin
        food_regen = food_hit;
        state_d    = grow ? ST_DRAW : ST_ERASE;
      end
      ST_ERASE:   if (accept) state_d = ST_DRAW;
      ST_DRAW:    if (accept) state_d = ST_IDLE;
      ST_OVER:    state_d = ST_OVER;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dir_q            <= DIR_RIGHT;
      pend_q           <= DIR_RIGHT;
      head_x           <= 8'(START_X);
      head_y           <= 7'(START_Y);
      head_ptr         <= AW'(START_LEN - 1);
      tail_ptr         <= '0;
      scan_ptr         <= '0;
      scan_cnt         <= '0;
      length           <= LW'(START_LEN);
      game_over        <= 1'b0;
      plot.plot_valid  <= 1'b0;
      plot.plot_x      <= '0;
      plot.plot_y      <= '0;
      plot.plot_colour <= '0;
    end else begin
      if (dir_valid && (dir_t'(dir_req) != reverse_dir(dir_ref))) pend_q <= dir_t'(dir_req);
      if (state_d == ST_OVER) game_over <= 1'b1;

      case (state_q)
        ST_ADVANCE: begin
          dir_q <= pend_q;
          if (head_step) begin
            head_x   <= nx;
            head_y   <= ny;
            head_ptr <= head_ptr + AW'(1);
          end
          scan_ptr <= tail_ptr + AW'(1);
          scan_cnt <= length - LW'(1);
        end
        ST_SCAN: begin
          scan_ptr <= scan_ptr + AW'(1);
          scan_cnt <= scan_cnt - LW'(1);
        end
        ST_CHECK: begin
          plot.plot_valid <= 1'b1;
          if (grow) begin
            length           <= length + LW'(1);
            plot.plot_x      <= head_x;
            plot.plot_y      <= head_y;
            plot.plot_colour <= SNAKE_COLOUR;
          end else begin
            plot.plot_x      <= seg_rd[14:7];
            plot.plot_y      <= seg_rd[6:0];
            plot.plot_colour <= COLOUR_ERASE;
          end
        end
        ST_ERASE: begin
          if (accept) begin
            tail_ptr         <= tail_ptr + AW'(1);
            plot.plot_x      <= head_x;
            plot.plot_y      <= head_y;
            plot.plot_colour <= SNAKE_COLOUR;
          end
        end
        ST_DRAW: begin
          if (accept) plot.plot_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl. The reference model keeps the body
// as a queue of cells (tail at front, head at back) and derives each move's
// expected pixel requests, food pulse, head, length and game_over.
module tb_snake_body_ctrl;
  localparam int MAX_LEN = 32;
  localparam int START_LEN = 4;
  localparam int START_X = 80;
  localparam int START_Y = 60;
  localparam int X_MAX = 159;
  localparam int Y_MAX = 119;
  localparam int LW = $clog2(MAX_LEN) + 1;
`ifdef SNAKE_WALL_KILL_EN
  localparam bit WALL_KILL = 1'b1;
`else
  localparam bit WALL_KILL = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          tick = 1'b0;
  logic [1:0]    dir_req = 2'b00;
  logic          dir_valid = 1'b0;
  logic          food_hit = 1'b0;
  logic [7:0]    head_x;
  logic [6:0]    head_y;
  logic          food_regen;
  logic [LW-1:0] length;
  logic          game_over;
  logic          busy;

  snake_body_ctrl_if pif();

  snake_body_ctrl #(
    .MAX_LEN(MAX_LEN), .START_LEN(START_LEN), .START_X(START_X), .START_Y(START_Y),
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .SNAKE_COLOUR(3'b010)
  ) dut (
    .clock(clock), .resetn(resetn), .tick(tick), .dir_req(dir_req), .dir_valid(dir_valid),
    .food_hit(food_hit), .head_x(head_x), .head_y(head_y), .food_regen(food_regen),
    .plot(pif), .length(length), .game_over(game_over), .busy(busy)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [14:0] body[$];
  int m_dir, m_hx, m_hy;
  bit m_over;

  task automatic model_reset();
    body.delete();
    for (int k = START_LEN - 1; k >= 0; k--) body.push_back({8'(START_X - k), 7'(START_Y)});
    m_dir = 0; m_hx = START_X; m_hy = START_Y; m_over = 0;
  endtask

  task automatic apply_reset();
    resetn = 1'b0; tick = 1'b0; dir_valid = 1'b0; food_hit = 1'b0; pif.plot_ready = 1'b1;
    repeat (2) @(negedge clock);
    resetn = 1'b1;
    model_reset();
    @(negedge clock);
  endtask

  // One move: optional direction request, tick, then watch the DUT until idle.
  task automatic do_move(input bit give_dir, input logic [1:0] dir, input bit food,
                         input bit stall, input string tag, output int lat);
    logic [17:0] exp_q[$];
    logic [17:0] got_q[$];
    logic [17:0] held;
    int nx, ny, regen_exp, regen_got, cyc;
    bit wall, hit, done, pend;
    exp_q.delete(); got_q.delete();
    if (give_dir) begin
      @(negedge clock); dir_req = dir; dir_valid = 1'b1;
      @(negedge clock); dir_valid = 1'b0;
      if (!m_over && (int'(dir) != (m_dir ^ 2))) m_dir = int'(dir);
    end
    regen_exp = 0;
    if (!m_over) begin
      nx = m_hx; ny = m_hy; wall = 0;
      case (m_dir)
        0: if (nx == X_MAX) begin nx = 0; wall = 1; end else nx = nx + 1;
        1: if (ny == 0) begin ny = Y_MAX; wall = 1; end else ny = ny - 1;
        2: if (nx == 0) begin nx = X_MAX; wall = 1; end else nx = nx - 1;
        default: if (ny == Y_MAX) begin ny = 0; wall = 1; end else ny = ny + 1;
      endcase
      if (wall && WALL_KILL) m_over = 1;
      else begin
        hit = 0;
        for (int i = 1; i < body.size(); i++) if (body[i] == {8'(nx), 7'(ny)}) hit = 1;
        m_hx = nx; m_hy = ny;
        if (hit) m_over = 1;
        else begin
          if (food) regen_exp = 1;
          if (!(food && body.size() < MAX_LEN)) begin
            exp_q.push_back({body[0], 3'b000});
            void'(body.pop_front());
          end
          body.push_back({8'(nx), 7'(ny)});
          exp_q.push_back({8'(nx), 7'(ny), 3'b010});
        end
      end
    end

    food_hit = food;
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    cyc = 0; done = 0; pend = 0; regen_got = 0; held = '0;
    while (!done && cyc < 400) begin
      if (pend) begin
        checks++;
        if (pif.plot_valid !== 1'b1 || {pif.plot_x, pif.plot_y, pif.plot_colour} !== held) begin
          errors++;
          $display("FAIL %s hold: valid=%b data=%h, required valid=1 data=%h", tag, pif.plot_valid,
                   {pif.plot_x, pif.plot_y, pif.plot_colour}, held);
        end
      end
      if (food_regen === 1'b1) regen_got++;
      if (busy !== 1'b1) done = 1;
      else begin
        pif.plot_ready = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        pend = 0;
        if (pif.plot_valid === 1'b1) begin
          if (pif.plot_ready) got_q.push_back({pif.plot_x, pif.plot_y, pif.plot_colour});
          else begin pend = 1; held = {pif.plot_x, pif.plot_y, pif.plot_colour}; end
        end
        @(negedge clock); cyc++;
      end
    end
    food_hit = 1'b0; pif.plot_ready = 1'b1;
    lat = cyc;

    checks++;
    if (!done) begin errors++; $display("FAIL %s timeout: busy still %b after %0d cycles", tag, busy, cyc); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s plot count: got %0d, required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s plot[%0d]: got x=%0d y=%0d c=%b, required x=%0d y=%0d c=%b", tag, i,
                 got_q[i][17:10], got_q[i][9:3], got_q[i][2:0], exp_q[i][17:10], exp_q[i][9:3], exp_q[i][2:0]);
      end
    end
    checks++;
    if (regen_got != regen_exp) begin errors++; $display("FAIL %s food_regen cycles: got %0d, required %0d", tag, regen_got, regen_exp); end
    checks++;
    if (head_x !== 8'(m_hx) || head_y !== 7'(m_hy)) begin
      errors++; $display("FAIL %s head: got (%0d,%0d), required (%0d,%0d)", tag, head_x, head_y, m_hx, m_hy);
    end
    checks++;
    if (length !== LW'(body.size())) begin errors++; $display("FAIL %s length: got %0d, required %0d", tag, length, body.size()); end
    checks++;
    if (game_over !== m_over) begin errors++; $display("FAIL %s game_over: got %b, required %b", tag, game_over, m_over); end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (head_x !== 8'd80 || head_y !== 7'd60) begin errors++; $display("FAIL reset head: got (%0d,%0d), required (80,60)", head_x, head_y); end
    checks++;
    if (length !== LW'(4)) begin errors++; $display("FAIL reset length: got %0d, required 4", length); end
    checks++;
    if (pif.plot_valid !== 1'b0 || food_regen !== 1'b0 || game_over !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset flags: valid=%b regen=%b over=%b busy=%b, required all 0", pif.plot_valid, food_regen, game_over, busy);
    end
    checks++;
    if ({pif.plot_x, pif.plot_y, pif.plot_colour} !== 18'd0) begin
      errors++; $display("FAIL reset plot data: got %h, required 0", {pif.plot_x, pif.plot_y, pif.plot_colour});
    end
  endtask

  task automatic test_single_move();
    int lat;
    apply_reset();
    do_move(0, 2'b00, 0, 0, "single", lat);
    checks++;
    if (lat != START_LEN + 3) begin errors++; $display("FAIL single latency: got %0d, required %0d", lat, START_LEN + 3); end
    checks++;
    if (busy !== 1'b0 || head_x !== 8'd81) begin errors++; $display("FAIL single end: busy=%b head_x=%0d, required busy=0 head_x=81", busy, head_x); end
  endtask

  task automatic test_turns();
    int lat;
    apply_reset();
    do_move(1, 2'b10, 0, 0, "reverse", lat);
    checks++;
    if (head_x !== 8'd81 || head_y !== 7'd60) begin errors++; $display("FAIL reverse head: got (%0d,%0d), required (81,60)", head_x, head_y); end
    do_move(1, 2'b01, 0, 0, "turn_up", lat);
    checks++;
    if (head_x !== 8'd81 || head_y !== 7'd59) begin errors++; $display("FAIL turn_up head: got (%0d,%0d), required (81,59)", head_x, head_y); end
    do_move(1, 2'b10, 0, 1, "turn_left", lat);
    checks++;
    if (head_x !== 8'd80 || head_y !== 7'd59) begin errors++; $display("FAIL turn_left head: got (%0d,%0d), required (80,59)", head_x, head_y); end
  endtask

  task automatic test_grow_full_wrap();
    int lat, guard;
    apply_reset();
    do_move(0, 2'b00, 1, 0, "grow", lat);
    checks++;
    if (lat != START_LEN + 2 || length !== LW'(5)) begin
      errors++; $display("FAIL grow: latency %0d length %0d, required latency %0d length 5", lat, length, START_LEN + 2);
    end
    guard = 0;
    while (body.size() < MAX_LEN && guard < 64) begin do_move(0, 2'b00, 1, guard[0], "fill", lat); guard++; end
    do_move(0, 2'b00, 1, 0, "full_food", lat);
    checks++;
    if (length !== LW'(MAX_LEN)) begin errors++; $display("FAIL full_food length: got %0d, required %0d", length, MAX_LEN); end
    guard = 0;
    while (m_hx != X_MAX && guard < 200) begin do_move(0, 2'b00, 0, 0, "to_edge", lat); guard++; end
    do_move(0, 2'b00, 0, 0, "wrap", lat);
    checks++;
    if (head_x !== (WALL_KILL ? 8'd159 : 8'd0) || game_over !== WALL_KILL) begin
      errors++; $display("FAIL wrap: head_x=%0d over=%b, required head_x=%0d over=%b", head_x, game_over, WALL_KILL ? 159 : 0, WALL_KILL);
    end
  endtask

  task automatic test_self_collision();
    int lat, seen;
    apply_reset();
    do_move(0, 2'b00, 1, 0, "sc_grow", lat);
    do_move(1, 2'b01, 0, 0, "sc_up", lat);
    do_move(1, 2'b10, 0, 0, "sc_left", lat);
    do_move(1, 2'b11, 0, 0, "sc_down", lat);
    checks++;
    if (game_over !== 1'b1) begin errors++; $display("FAIL self_collision game_over: got %b, required 1", game_over); end
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick = (i == 1 || i == 5);
      if (pif.plot_valid === 1'b1 || busy === 1'b1) seen++;
      @(negedge clock);
    end
    tick = 1'b0;
    checks++;
    if (seen != 0 || game_over !== 1'b1) begin errors++; $display("FAIL over ticks: active cycles %0d over=%b, required 0 and 1", seen, game_over); end
    resetn = 1'b0;
    #1;
    checks++;
    if (game_over !== 1'b0 || head_x !== 8'd80) begin errors++; $display("FAIL over reset: over=%b head_x=%0d, required 0 and 80", game_over, head_x); end
    @(negedge clock); resetn = 1'b1; model_reset(); @(negedge clock);
  endtask

  task automatic test_backpressure();
    logic [17:0] held;
    int waitc, bad, n_acc;
    apply_reset();
    pif.plot_ready = 1'b0;
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    waitc = 0;
    while (pif.plot_valid !== 1'b1 && waitc < 50) begin @(negedge clock); waitc++; end
    held = {pif.plot_x, pif.plot_y, pif.plot_colour};
    checks++;
    if (held !== {8'd77, 7'd60, 3'b000} || pif.plot_valid !== 1'b1) begin
      errors++; $display("FAIL stall erase: valid=%b data=%h, required valid=1 data=%h", pif.plot_valid, held, {8'd77, 7'd60, 3'b000});
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick = (i == 3);
      if (pif.plot_valid !== 1'b1 || {pif.plot_x, pif.plot_y, pif.plot_colour} !== held) bad++;
      @(negedge clock);
    end
    tick = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall hold: %0d unstable cycles, required 0", bad); end
    pif.plot_ready = 1'b1;
    n_acc = 0; waitc = 0;
    while (busy === 1'b1 && waitc < 50) begin
      if (pif.plot_valid === 1'b1) n_acc++;
      @(negedge clock); waitc++;
    end
    repeat (10) begin if (busy !== 1'b0) bad++; @(negedge clock); end
    checks++;
    if (n_acc != 2 || bad != 0 || head_x !== 8'd81) begin
      errors++; $display("FAIL dropped tick: accepts %0d busy_cycles %0d head_x %0d, required 2 0 81", n_acc, bad, head_x);
    end
    pif.plot_ready = 1'b0;
    @(negedge clock); tick = 1'b1;
    @(negedge clock); tick = 1'b0;
    waitc = 0;
    while (pif.plot_valid !== 1'b1 && waitc < 50) begin @(negedge clock); waitc++; end
    repeat (3) @(negedge clock);
    checks++;
    if (pif.plot_valid !== 1'b1) begin errors++; $display("FAIL pre-reset valid: got %b, required 1", pif.plot_valid); end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if (pif.plot_valid !== 1'b0 || busy !== 1'b0 || head_x !== 8'd80) begin
      errors++; $display("FAIL async reset: valid=%b busy=%b head_x=%0d, required 0 0 80", pif.plot_valid, busy, head_x);
    end
    @(negedge clock); resetn = 1'b1; pif.plot_ready = 1'b1; model_reset(); @(negedge clock);
  endtask

  task automatic test_random();
    int lat;
    bit gd, fd, st;
    logic [1:0] d;
    apply_reset();
    for (int n = 0; n < 120; n++) begin
      if (m_over) apply_reset();
      gd = ($urandom_range(0, 1) == 1);
      d  = 2'($urandom_range(0, 3));
      fd = ($urandom_range(0, 4) == 0);
      st = ($urandom_range(0, 1) == 1);
      do_move(gd, d, fd, st, "random", lat);
    end
  endtask

  initial begin
    pif.plot_ready = 1'b1;
    test_reset();
    test_single_move();
    test_turns();
    test_grow_full_wrap();
    test_self_collision();
    test_backpressure();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
